// File: rtl/pc_seq_pkg.sv
// Shared definitions for the pc_sequencer fetch/decode/execute controller:
// opcode encodings, the HALT instruction, FSM states and the control vector.
package pc_seq_pkg;

    localparam logic [1:0] OP_NEXT   = 2'b00;
    localparam logic [1:0] OP_PAGE   = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    localparam logic [7:0] HALT_INSTR = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        HALT
    } state_e;

    // One-hot control pulses towards the program counter.
    typedef struct packed {
        logic lsbs;
        logic msbs;
        logic jump;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational instruction decoder: maps the latched instruction and the
// branch condition to a one-hot control vector plus a halt indication.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  logic [7:0] ir_i,
    input  logic       cond_i,
    output ctrl_t      ctrl_o,
    output logic       is_halt_o
);

    // Opcode decode; HALT is carved out of the NEXT opcode space.
    always_comb begin
        ctrl_o    = '0;
        is_halt_o = 1'b0;
        case (ir_i[7:6])
            OP_NEXT: begin
                if (ir_i == HALT_INSTR) begin
                    is_halt_o = 1'b1;
                end else begin
                    ctrl_o.lsbs = 1'b1;
                end
            end
            OP_PAGE: ctrl_o.msbs = 1'b1;
            OP_JUMP: ctrl_o.jump = 1'b1;
            default: begin
                if (cond_i) begin
                    ctrl_o.branch = 1'b1;
                end else begin
                    ctrl_o.lsbs = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller driving program_counter_v1.
// Optional macro PC_SEQ_MEM_READY_EN adds a mem_ready input that can
// stretch FETCH beyond MEM_LATENCY cycles.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PC_SEQ_MEM_READY_EN
    input  logic               mem_ready,
`endif
    input  logic [7:0]         instr,
    input  logic               cond,
    output logic               update_lsbs,
    output logic               update_msbs,
    output logic               jump,
    output logic [5:0]         jump_destination,
    output logic               branch,
    output logic [5:0]         branch_offset,
    output logic               halted,
    output logic [COUNT_W-1:0] retired_count
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           ir_q, ir_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic [5:0]           dest_q, dest_d;
    logic [5:0]           off_q, off_d;
    logic                 halted_q, halted_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;

    ctrl_t                dec_ctrl;
    logic                 dec_halt;
    logic                 fetch_done;

    pc_seq_decode u_decode (
        .ir_i      (ir_q),
        .cond_i    (cond),
        .ctrl_o    (dec_ctrl),
        .is_halt_o (dec_halt)
    );

`ifdef PC_SEQ_MEM_READY_EN
    assign fetch_done = (cnt_q == '0) && mem_ready;
`else
    assign fetch_done = (cnt_q == '0);
`endif

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ir_q      <= '0;
            ctrl_q    <= '0;
            dest_q    <= '0;
            off_q     <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            ctrl_q    <= ctrl_d;
            dest_q    <= dest_d;
            off_q     <= off_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic; the EXECUTE decision is registered so pulses appear
    // for exactly one cycle right after EXECUTE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        ctrl_d    = '0;
        dest_d    = dest_q;
        off_d     = off_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                cnt_d   = LAT_LOAD;
                state_d = FETCH;
            end
            FETCH: begin
                if (fetch_done) begin
                    state_d = DECODE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DECODE: begin
                ir_d    = instr;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                ctrl_d    = dec_ctrl;
                retired_d = retired_q + COUNT_W'(1);
                cnt_d     = LAT_LOAD;
                if (dec_ctrl.jump) begin
                    dest_d = ir_q[5:0];
                end
                if (dec_ctrl.branch) begin
                    off_d = ir_q[5:0];
                end
                if (dec_halt) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign update_lsbs      = ctrl_q.lsbs;
    assign update_msbs      = ctrl_q.msbs;
    assign jump             = ctrl_q.jump;
    assign branch           = ctrl_q.branch;
    assign jump_destination = dest_q;
    assign branch_offset    = off_q;
    assign halted           = halted_q;
    assign retired_count    = retired_q;

endmodule
